// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
package stream_rr_arbiter_pkg;

  // Width of a source index: at least one bit, even for tiny arbiters.
  function automatic int src_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Packet-lock state, used only when last-based locking is compiled in.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: returns the first set request bit
// found when scanning from pointer upward, wrapping modulo N.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic          found,
  output logic [PW-1:0] index
);

  logic [PW-1:0] cand;

  // Scan from the farthest candidate back to the pointer so that the
  // candidate closest to the pointer is the last (winning) assignment.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(pointer) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin arbiter onto one registered valid/ready stream.
// output_source tags each beat with the index of the input that sent it.
// Optional packet locking (input_last/output_last) is enabled by defining
// STREAM_RR_ARBITER_LAST_LOCK_EN.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  parameter  int DATA_BITS  = 8,
  localparam int SRC_BITS   = src_bits(NUM_INPUTS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_INPUTS-1:0]                input_valid,
  output logic [NUM_INPUTS-1:0]                input_ready,
  input  logic [NUM_INPUTS-1:0][DATA_BITS-1:0] input_data,
`ifdef STREAM_RR_ARBITER_LAST_LOCK_EN
  input  logic [NUM_INPUTS-1:0]                input_last,
  output logic                                 output_last,
`endif
  output logic                                 output_valid,
  input  logic                                 output_ready,
  output logic [DATA_BITS-1:0]                 output_data,
  output logic [SRC_BITS-1:0]                  output_source
);

  logic                  load;
  logic                  found;
  logic                  grant;
  logic                  beat_last;
  logic [SRC_BITS-1:0]   win;
  logic [SRC_BITS-1:0]   pointer;
  logic [SRC_BITS-1:0]   next_pointer;
  logic [NUM_INPUTS-1:0] req;

  // The output register can take a beat when it is empty or being drained.
  assign load  = !output_valid || output_ready;
  // Ready is also masked during reset so no requester sees a handshake.
  assign grant = load && found && !reset;
  assign input_ready  = grant ? (NUM_INPUTS'(1) << win) : '0;
  assign next_pointer = (win == SRC_BITS'(NUM_INPUTS - 1)) ? '0 : win + 1'b1;

`ifdef STREAM_RR_ARBITER_LAST_LOCK_EN
  lock_state_t         state_q;
  lock_state_t         state_d;
  logic [SRC_BITS-1:0] lock_idx;

  // While locked only the packet owner may compete.
  assign req       = (state_q == LOCKED) ? (input_valid & (NUM_INPUTS'(1) << lock_idx))
                                         : input_valid;
  assign beat_last = input_last[win];

  // Next lock state: a granted non-final beat locks, a granted final beat unlocks.
  always_comb begin
    state_d = state_q;
    if (grant) state_d = beat_last ? IDLE : LOCKED;
  end

  // Lock state register and the owner of the packet in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lock_idx <= '0;
    end else begin
      state_q <= state_d;
      if (grant) lock_idx <= win;
    end
  end

  // The last flag travels with the registered beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) output_last <= 1'b0;
    else if (grant) output_last <= beat_last;
  end
`else
  assign req       = input_valid;
  assign beat_last = 1'b1;
`endif

  rr_priority_picker #(
    .N  (NUM_INPUTS),
    .PW (SRC_BITS)
  ) u_picker (
    .req     (req),
    .pointer (pointer),
    .found   (found),
    .index   (win)
  );

  // Output stage and round-robin pointer; both hold while the stage is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      output_valid  <= 1'b0;
      output_data   <= '0;
      output_source <= '0;
      pointer       <= '0;
    end else if (load) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      output_valid <= found;
      if (found) begin
        output_data   <= input_data[win];
        output_source <= win;
        if (beat_last) pointer <= next_pointer;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (4 inputs, 8-bit data).
// Packet-lock steps run only when STREAM_RR_ARBITER_LAST_LOCK_EN is defined.
module tb_stream_rr_arbiter;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       input_valid;
  logic [3:0]       input_ready;
  logic [3:0][7:0]  input_data;
  logic             output_valid;
  logic             output_ready;
  logic [7:0]       output_data;
  logic [1:0]       output_source;
`ifdef STREAM_RR_ARBITER_LAST_LOCK_EN
  logic [3:0]       input_last;
  logic             output_last;
`endif

  int checks   = 0;
  int failures = 0;

  stream_rr_arbiter #(.NUM_INPUTS(4), .DATA_BITS(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .input_valid   (input_valid),
    .input_ready   (input_ready),
    .input_data    (input_data),
`ifdef STREAM_RR_ARBITER_LAST_LOCK_EN
    .input_last    (input_last),
    .output_last   (output_last),
`endif
    .output_valid  (output_valid),
    .output_ready  (output_ready),
    .output_data   (output_data),
    .output_source (output_source)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] hs_in;
    logic       hs_out;
    logic [7:0] od;
    logic [1:0] os;
    logic [7:0] seq [4];
    logic [7:0] exp_seq [4];
    int         wait_cnt [4];
    int         beats;
    int         cycles;

    // 1: reset held two cycles with every input valid
    reset        = 1'b1;
    input_valid  = 4'b1111;
    output_ready = 1'b1;
    for (int i = 0; i < 4; i++) input_data[i] = 8'(i);
`ifdef STREAM_RR_ARBITER_LAST_LOCK_EN
    input_last = 4'b1111;
`endif
    #1;
    for (int c = 0; c < 2; c++) begin
      check("rst_ready", 32'(input_ready), 32'h0);
      check("rst_valid", 32'(output_valid), 32'h0);
      tick();
    end
    check("rst_data", 32'(output_data), 32'h0);
    check("rst_src", 32'(output_source), 32'h0);
    reset = 1'b0;

    // 2: all valid, full throughput, pointer wraps 3 -> 0
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ready", 32'(input_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check("rr_valid", 32'(output_valid), 32'h1);
      check("rr_src", 32'(output_source), 32'(k % 4));
      check("rr_data", 32'(output_data), 32'(k % 4));
    end

    // 3: single requester (input 2), sixteen back-to-back beats
    input_valid = 4'b0100;
    for (int j = 0; j < 16; j++) begin
      input_data[2] = 8'(j);
      #1;
      check("single_ready", 32'(input_ready), 32'h4);
      tick();
      check("single_valid", 32'(output_valid), 32'h1);
      check("single_src", 32'(output_source), 32'h2);
      check("single_data", 32'(output_data), 32'(j));
    end

    // 4: stall with beat 0xA5 from input 1 held
    input_valid   = 4'b0010;
    input_data[1] = 8'hA5;
    tick();
    check("hold_load_src", 32'(output_source), 32'h1);
    output_ready = 1'b0;
    input_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) input_data[i] = 8'(i);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("hold_ready", 32'(input_ready), 32'h0);
      tick();
      check("hold_valid", 32'(output_valid), 32'h1);
      check("hold_data", 32'(output_data), 32'hA5);
      check("hold_src", 32'(output_source), 32'h1);
    end
    output_ready = 1'b1;
    #1;
    check("release_ready", 32'(input_ready), 32'h4);
    tick();
    check("release_src", 32'(output_source), 32'h2);
    check("release_data", 32'(output_data), 32'h2);

    // Drain: loading with nothing valid empties the stage, data/source hold
    input_valid = 4'b0000;
    tick();
    check("drain_valid", 32'(output_valid), 32'h0);
    check("drain_src", 32'(output_source), 32'h2);

    // 5: random traffic, sticky valids, in-order and fairness model
    v = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 8'h00;
      exp_seq[i] = 8'h00;
      wait_cnt[i] = 0;
    end
    beats  = 0;
    cycles = 0;
    while (beats < 1000 && cycles < 20000) begin
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && $urandom_range(9) < 8) v[i] = 1'b1;
        input_data[i] = seq[i];
      end
      input_valid  = v;
      output_ready = ($urandom_range(9) < 4);
      #1;
      hs_in  = input_ready & input_valid;
      hs_out = output_valid && output_ready;
      od     = output_data;
      os     = output_source;
      check("rand_onehot", 32'($onehot0(input_ready)), 32'h1);
      if (hs_out) begin
        check("rand_order", 32'(od), 32'(exp_seq[os]));
        exp_seq[os] = exp_seq[os] + 8'h01;
        beats++;
      end
      for (int i = 0; i < 4; i++) begin
        if (hs_in[i]) begin
          seq[i]      = seq[i] + 8'h01;
          wait_cnt[i] = 0;
        end else if (v[i] && hs_in != 4'b0000) begin
          wait_cnt[i]++;
          checks++;
          assert (wait_cnt[i] <= 3) else begin
            failures++;
            $error("FAIL starve input=%0d observed=%0d expected<=3", i, wait_cnt[i]);
          end
        end
      end
      tick();
      v = v & ~hs_in;
      cycles++;
    end
    check("rand_beats", 32'(beats), 32'd1000);

    // Reset mid-operation discards the held beat
    output_ready = 1'b0;
    input_valid  = 4'b1111;
    tick();
    check("midrst_pre", 32'(output_valid), 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(output_valid), 32'h0);
    check("midrst_ready", 32'(input_ready), 32'h0);
    tick();
    reset        = 1'b0;
    output_ready = 1'b1;
    input_valid  = 4'b0000;
    tick();
    check("midrst_nodup", 32'(output_valid), 32'h0);

`ifdef STREAM_RR_ARBITER_LAST_LOCK_EN
    // 6: input 0 sends a 4-beat packet while input 1 waits
    input_valid   = 4'b0011;
    input_data[1] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      input_data[0] = 8'h10 + 8'(k);
      input_last    = (k == 3) ? 4'b0011 : 4'b0010;
      #1;
      check("lock_ready", 32'(input_ready), 32'h1);
      tick();
      check("lock_src", 32'(output_source), 32'h0);
      check("lock_data", 32'(output_data), 32'(8'h10 + 8'(k)));
      check("lock_last", 32'(output_last), 32'(k == 3));
    end
    input_valid = 4'b0010;
    #1;
    check("unlock_ready", 32'(input_ready), 32'h2);
    tick();
    check("unlock_src", 32'(output_source), 32'h1);
    check("unlock_data", 32'(output_data), 32'h77);
    check("unlock_last", 32'(output_last), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
